// File: rtl/mem_axi_pkg.sv
// Shared types for the memory-to-AXI unit: FSM states, write-table entry
// layout and default sizing constants.
package mem_axi_pkg;

  localparam int WB_DEPTH_DEF = 4;
  localparam int RD_ID_DEF    = 15;

  typedef enum logic [2:0] {
    IDLE,
    RD_HOLD,
    RD_ADDR,
    RD_DATA,
    WR_HOLD,
    WR_SEND,
    FENCE
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
  } wb_entry_t;

endpackage

// File: rtl/wr_track_table.sv
// Outstanding-write table: one entry per in-flight AXI write ID, freed by the
// matching B response; also reports load/store word-address hazards.
module wr_track_table
  import mem_axi_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int ID_W     = 4,
  parameter int IDX_W    = $clog2(WB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_en,
  input  logic [31:0]      alloc_addr,
  input  logic [2:0]       alloc_size,
  input  logic             free_en,
  input  logic [ID_W-1:0]  free_id,
  input  logic [29:0]      cmp_word,
  output logic [IDX_W-1:0] free_idx,
  output logic             full,
  output logic             empty,
  output logic             hazard,
  output logic             id_err
);

  wb_entry_t entries_q [WB_DEPTH];
  wb_entry_t entries_d [WB_DEPTH];
  logic      free_hit;

  // Status is computed from the registered table, so a slot freed this cycle
  // only looks free from the next cycle on.
  always_comb begin
    entries_d = entries_q;
    free_idx  = '0;
    full      = 1'b1;
    empty     = 1'b1;
    hazard    = 1'b0;
    free_hit  = 1'b0;
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        free_idx = IDX_W'(i);
        full     = 1'b0;
      end else begin
        empty = 1'b0;
      end
      if (entries_q[i].valid && entries_q[i].addr[31:2] == cmp_word) hazard = 1'b1;
      if (free_en && entries_q[i].valid && free_id == ID_W'(i)) begin
        entries_d[i].valid = 1'b0;
        free_hit           = 1'b1;
      end
    end
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (alloc_en && !full && free_idx == IDX_W'(i)) begin
        entries_d[i] = '{valid: 1'b1, addr: alloc_addr, size: alloc_size};
      end
    end
    id_err = free_en && !free_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entries_q <= '{default: '0};
    else      entries_q <= entries_d;
  end

endmodule

// File: rtl/mem_axi_unit.sv
// Bridges a held load/store/fence request onto AXI read and write channels.
// The AXI R data input is named axi_rdata because rdata is the load result.
module mem_axi_unit
  import mem_axi_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int ID_W     = 4,
  parameter int RD_ID    = RD_ID_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_wr,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [3:0]      req_wstrb,
  input  logic [2:0]      req_size,
  input  logic            fence,
  output logic            done,
  output logic [31:0]     rdata,
  output logic            busy,
  output logic            wb_full,
  output logic            bid_err,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [2:0]      arsize,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     axi_rdata,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [2:0]      awsize,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic            bvalid,
  output logic            bready
);

  localparam int IDX_W = $clog2(WB_DEPTH);

  state_e            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              rd_done_q, rd_done_d;
  logic              bid_err_q, bid_err_d;
  logic              bready_q, bready_d;
  logic [ID_W-1:0]   awid_q, awid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              start_wr, wr_done, fence_done, b_fire;
  logic [IDX_W-1:0]  free_idx;
  logic              full, empty, hazard, id_err;

  assign b_fire = bvalid && bready_q;

  wr_track_table #(.WB_DEPTH(WB_DEPTH), .ID_W(ID_W)) u_table (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (start_wr),
    .alloc_addr(req_addr),
    .alloc_size(req_size),
    .free_en   (b_fire),
    .free_id   (bid),
    .cmp_word  (req_addr[31:2]),
    .free_idx  (free_idx),
    .full      (full),
    .empty     (empty),
    .hazard    (hazard),
    .id_err    (id_err)
  );

  // A load's done is registered, so IDLE ignores the still-held request in
  // that done cycle to avoid issuing the same load twice.
  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awid_d     = awid_q;
    rdata_d    = rdata_q;
    rd_done_d  = 1'b0;
    start_wr   = 1'b0;
    wr_done    = 1'b0;
    fence_done = 1'b0;
    bready_d   = 1'b1;
    bid_err_d  = bid_err_q | id_err;
    case (state_q)
      IDLE: begin
        if (req_valid && !rd_done_q) begin
          if (req_wr) begin
            if (full) state_d = WR_HOLD;
            else      start_wr = 1'b1;
          end else begin
            state_d = hazard ? RD_HOLD : RD_ADDR;
          end
        end else if (fence && !req_valid) begin
          state_d = FENCE;
        end
      end
      RD_HOLD: if (!hazard) state_d = RD_ADDR;
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        if (rvalid && rid == ID_W'(RD_ID)) begin
          rdata_d   = axi_rdata;
          rd_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_HOLD: if (!full) start_wr = 1'b1;
      WR_SEND: begin
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
          wr_done   = 1'b1;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          if (awready) awvalid_d = 1'b0;
          if (wready)  wvalid_d  = 1'b0;
        end
      end
      FENCE: begin
        if (empty) begin
          fence_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_wr) begin
      state_d   = WR_SEND;
      awid_d    = ID_W'(free_idx);
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rd_done_q <= 1'b0;
      bid_err_q <= 1'b0;
      bready_q  <= 1'b0;
      awid_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rd_done_q <= rd_done_d;
      bid_err_q <= bid_err_d;
      bready_q  <= bready_d;
      awid_q    <= awid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign done    = rd_done_q | wr_done | fence_done;
  assign rdata   = rdata_q;
  assign busy    = (state_q != IDLE);
  assign wb_full = full;
  assign bid_err = bid_err_q;
  assign bready  = bready_q;

  assign arid    = ID_W'(RD_ID);
  assign araddr  = {req_addr[31:2], 2'b00};
  assign arsize  = 3'b010;
  assign arvalid = (state_q == RD_ADDR);
  assign rready  = (state_q == RD_DATA);

  assign awid    = awid_q;
  assign awaddr  = req_addr;
  assign awsize  = req_size;
  assign awvalid = awvalid_q;
  assign wid     = awid_q;
  assign wdata   = req_wdata;
  assign wstrb   = req_wstrb;
  assign wvalid  = wvalid_q;

endmodule

// File: tb/tb_mem_axi_unit.sv
// Self-checking bench for mem_axi_unit: directed scenarios followed by a
// randomized mix checked against a table-of-outstanding-writes model.
module tb_mem_axi_unit;

  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        req_valid, req_wr, fence;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [2:0]  req_size;
  logic        done, busy, wb_full, bid_err;
  logic [31:0] rdata;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, axi_rdata, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int n_tests = 0;
  int n_fail  = 0;

  bit          mv [DEPTH];
  logic [31:0] ma [DEPTH];
  bit          merr;

  mem_axi_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
    .fence(fence), .done(done), .rdata(rdata), .busy(busy),
    .wb_full(wb_full), .bid_err(bid_err),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
    .arready(arready), .rid(rid), .axi_rdata(axi_rdata), .rvalid(rvalid),
    .rready(rready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bid(bid),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < DEPTH; i++) if (!mv[i]) return i;
    return -1;
  endfunction

  function automatic bit model_any();
    for (int i = 0; i < DEPTH; i++) if (mv[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h3000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
  endfunction

  task automatic send_b(input int id);
    bvalid = 1'b1;
    bid    = 4'(id);
    cyc();
    bvalid = 1'b0;
    if (id < DEPTH && mv[id]) mv[id] = 1'b0;
    else                      merr = 1'b1;
    check_output("bid_err", bid_err, merr);
    check_output("wb_full_after_b", wb_full, lowest_free() < 0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data,
                         input int rdelay, input bit bad_beat);
    bit hz;
    int n;
    hz = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (mv[i] && ma[i][31:2] == addr[31:2]) hz = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_size = 3'd2;
    cyc();
    if (hz) begin
      repeat (2) begin
        check_output("hold_arvalid", arvalid, 0);
        check_output("hold_busy", busy, 1);
        cyc();
      end
      for (int i = 0; i < DEPTH; i++) if (mv[i] && ma[i][31:2] == addr[31:2]) send_b(i);
    end
    n = 0;
    while (!arvalid && n < 4) begin cyc(); n++; end
    check_output("arvalid", arvalid, 1);
    check_output("araddr", araddr, {addr[31:2], 2'b00});
    check_output("arid", arid, 15);
    check_output("arsize", arsize, 3'b010);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    check_output("rready", rready, 1);
    if (bad_beat) begin
      rvalid = 1'b1; rid = 4'd3; axi_rdata = $urandom;
      cyc();
      rvalid = 1'b0;
      check_output("bad_rid_done", done, 0);
    end
    repeat (rdelay) cyc();
    rvalid = 1'b1; rid = 4'd15; axi_rdata = data;
    cyc();
    rvalid = 1'b0;
    check_output("load_done", done, 1);
    check_output("load_rdata", rdata, data);
    req_valid = 1'b0;
    cyc();
    check_output("load_done_once", done, 0);
    check_output("load_idle", busy, 0);
  endtask

  task automatic start_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = addr;
    req_wdata = data; req_wstrb = strb; req_size = 3'd2;
  endtask

  task automatic complete_store(input int da, input int dw);
    int n, exp_id, last;
    n = 0;
    while (!awvalid && n < 8) begin cyc(); n++; end
    check_output("awvalid", awvalid, 1);
    exp_id = lowest_free();
    check_output("awid", awid, 4'(exp_id));
    check_output("wid", wid, 4'(exp_id));
    check_output("awaddr", awaddr, req_addr);
    check_output("wdata", wdata, req_wdata);
    check_output("wstrb", wstrb, req_wstrb);
    last = (da > dw) ? da : dw;
    for (int k = 0; k <= last; k++) begin
      awready = (k == da);
      wready  = (k == dw);
      #1;
      check_output("awvalid_hold", awvalid, k <= da);
      check_output("wvalid_hold", wvalid, k <= dw);
      check_output("store_done", done, k == last);
      cyc();
    end
    awready = 1'b0; wready = 1'b0; req_valid = 1'b0;
    if (exp_id >= 0) begin
      mv[exp_id] = 1'b1;
      ma[exp_id] = req_addr;
    end
    check_output("store_done_once", done, 0);
    check_output("store_idle", busy, 0);
  endtask

  task automatic do_store(input logic [31:0] addr, input int da, input int dw);
    start_store(addr, $urandom, 4'($urandom_range(1, 15)));
    complete_store(da, dw);
  endtask

  task automatic do_fence();
    int n;
    fence = 1'b1;
    #1;
    check_output("fence_idle_done", done, 0);
    cyc();
    while (model_any()) begin
      check_output("fence_wait_done", done, 0);
      send_b(lowest_free() < 0 ? 0 : (mv[0] ? 0 : (mv[1] ? 1 : (mv[2] ? 2 : 3))));
    end
    n = 0;
    while (!done && n < 3) begin cyc(); n++; end
    check_output("fence_done", done, 1);
    fence = 1'b0;
    cyc();
    check_output("fence_done_once", done, 0);
  endtask

  task automatic apply_stimulus(input int n_ops);
    int op, id;
    for (int t = 0; t < n_ops; t++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_load(rand_addr(), $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (op <= 6) begin
        if (lowest_free() >= 0) do_store(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3));
        else                    send_b($urandom_range(0, DEPTH - 1));
      end else if (op == 7) begin
        id = $urandom_range(0, DEPTH - 1);
        if (mv[id]) send_b(id);
      end else if (op == 8) begin
        id = $urandom_range(0, 15);
        if (id < DEPTH && mv[id]) id = id + DEPTH;
        send_b(id);
      end else begin
        do_fence();
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; req_size = 0;
    fence = 0; arready = 0; rid = 0; axi_rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bvalid = 0;
    for (int i = 0; i < DEPTH; i++) begin mv[i] = 0; ma[i] = 0; end
    merr = 0;

    #3;
    check_output("rst_done", done, 0);
    check_output("rst_arvalid", arvalid, 0);
    check_output("rst_awvalid", awvalid, 0);
    check_output("rst_wvalid", wvalid, 0);
    check_output("rst_rready", rready, 0);
    check_output("rst_bid_err", bid_err, 0);
    check_output("rst_rdata", rdata, 0);
    check_output("rst_busy", busy, 0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    check_output("bready_after_rst", bready, 1);

    do_load(32'h1000, 32'hDEADBEEF, 3, 1'b0);

    start_store(32'h2004, 32'h1234_5678, 4'b1111);
    complete_store(2, 0);
    send_b(0);

    for (int i = 0; i < 4; i++) do_store(32'h4000 + 32'(i * 4), 0, 0);
    check_output("four_full", wb_full, 1);
    start_store(32'h4010, 32'hA5A5_A5A5, 4'b1111);
    repeat (3) begin
      check_output("hold_awvalid", awvalid, 0);
      check_output("hold_full", wb_full, 1);
      cyc();
    end
    send_b(2);
    complete_store(0, 1);
    for (int i = 0; i < DEPTH; i++) send_b(i);

    do_store(32'h3000, 1, 1);
    do_load(32'h3002, 32'hCAFE_F00D, 1, 1'b1);

    do_store(32'h5000, 0, 2);
    do_store(32'h5008, 1, 0);
    do_fence();
    do_fence();
    send_b(3);
    check_output("bid_err_free_id", bid_err, 1);

    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h6000; req_size = 3'd2;
    cyc();
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    check_output("pre_rst_rready", rready, 1);
    #2 rst = 1'b0;
    #1;
    check_output("midrst_rready", rready, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_rdata", rdata, 0);
    check_output("midrst_bid_err", bid_err, 0);
    check_output("midrst_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    merr = 0;
    req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check_output("post_rst_done", done, 0);
    check_output("post_rst_bready", bready, 1);
    do_load(32'h6000, 32'h0BAD_CAFE, 0, 1'b0);

    apply_stimulus(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
